// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// Holds the FSM encoding, command opcodes, headings and response bytes.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERT      = 3'd1,
    VERT_RESP = 3'd2,
    HORZ      = 3'd3,
    HORZ_RESP = 3'd4
  } tour_state_e;

  localparam int DEFAULT_NUM_MOVES = 24;

  localparam logic [3:0] MOVE         = 4'h2;
  localparam logic [3:0] MOVE_FANFARE = 4'h3;

  // +y is north, +x is east
  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [7:0] ACK_MID  = 8'hA5;
  localparam logic [7:0] ACK_DONE = 8'h5A;

  // Command word layout: [15:12] opcode, [11:4] heading, [3:0] squares.
  function automatic logic [15:0] pack_cmd(input logic [3:0] opcode,
                                           input logic [7:0] heading,
                                           input logic [1:0] squares);
    return {opcode, heading, 2'b00, squares};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
// Pure combinational; anything that is not exactly one-hot decodes to zero squares heading north.
module knight_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vert_hdg,
  output logic [1:0] vert_sq,
  output logic [7:0] horz_hdg,
  output logic [1:0] horz_sq
);

  always_comb begin
    vert_hdg = HDG_NORTH;
    vert_sq  = 2'd0;
    horz_hdg = HDG_NORTH;
    horz_sq  = 2'd0;
    case (move)
      8'h01: begin  // (+1,+2)
        vert_hdg = HDG_NORTH; vert_sq = 2'd2;
        horz_hdg = HDG_EAST;  horz_sq = 2'd1;
      end
      8'h02: begin  // (-1,+2)
        vert_hdg = HDG_NORTH; vert_sq = 2'd2;
        horz_hdg = HDG_WEST;  horz_sq = 2'd1;
      end
      8'h04: begin  // (-2,+1)
        vert_hdg = HDG_NORTH; vert_sq = 2'd1;
        horz_hdg = HDG_WEST;  horz_sq = 2'd2;
      end
      8'h08: begin  // (-2,-1)
        vert_hdg = HDG_SOUTH; vert_sq = 2'd1;
        horz_hdg = HDG_WEST;  horz_sq = 2'd2;
      end
      8'h10: begin  // (-1,-2)
        vert_hdg = HDG_SOUTH; vert_sq = 2'd2;
        horz_hdg = HDG_WEST;  horz_sq = 2'd1;
      end
      8'h20: begin  // (+1,-2)
        vert_hdg = HDG_SOUTH; vert_sq = 2'd2;
        horz_hdg = HDG_EAST;  horz_sq = 2'd1;
      end
      8'h40: begin  // (+2,-1)
        vert_hdg = HDG_SOUTH; vert_sq = 2'd1;
        horz_hdg = HDG_EAST;  horz_sq = 2'd2;
      end
      8'h80: begin  // (+2,+1)
        vert_hdg = HDG_NORTH; vert_sq = 2'd1;
        horz_hdg = HDG_EAST;  horz_sq = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Sequences a knight tour as vertical/horizontal command pairs, passing UART commands through while idle.
// State advances one clk after clr_cmd_rdy/send_resp; cmd, cmd_rdy and resp are combinational.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = DEFAULT_NUM_MOVES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  tour_state_e state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;

  logic [7:0]  vert_hdg, horz_hdg;
  logic [1:0]  vert_sq, horz_sq;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  knight_move_decode u_decode (
    .move     (move),
    .vert_hdg (vert_hdg),
    .vert_sq  (vert_sq),
    .horz_hdg (horz_hdg),
    .horz_sq  (horz_sq)
  );

  assign vert_cmd  = pack_cmd(MOVE, vert_hdg, vert_sq);
  assign horz_cmd  = pack_cmd(MOVE_FANFARE, horz_hdg, horz_sq);
  assign last_move = (mv_indx_q == LAST_INDX);
  assign mv_indx   = mv_indx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Each state only listens to the one strobe it waits for; others are dropped.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT: begin
        if (clr_cmd_rdy) state_d = VERT_RESP;
      end
      VERT_RESP: begin
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        if (clr_cmd_rdy) state_d = HORZ_RESP;
      end
      HORZ_RESP: begin
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = ACK_MID;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK_DONE;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
      end
      VERT_RESP: begin
        cmd = vert_cmd;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      HORZ_RESP: begin
        cmd  = horz_cmd;
        resp = last_move ? ACK_DONE : ACK_MID;
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK_DONE;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd: a solver/command-processor model drives tours and
// expected commands are computed from the (dx,dy) move table.
module tb_tour_cmd;

  localparam int N = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  int n_tests = 0;
  int n_fail  = 0;
  int cmd_count;

  logic [7:0] tour_moves [N];
  int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #10 clk = ~clk;

  // Solver stand-in: answers the move for whatever index the block asks for.
  assign move = (int'(mv_indx) < N) ? tour_moves[mv_indx] : 8'h00;

  tour_cmd #(.NUM_MOVES(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horiz);
    int cnt = 0;
    int bi = 0;
    int d;
    int sq;
    logic [7:0] hdg;
    for (int b = 0; b < 8; b++) if (m[b]) begin cnt++; bi = b; end
    if (cnt != 1) return horiz ? 16'h3000 : 16'h2000;
    d  = horiz ? dx_tab[bi] : dy_tab[bi];
    sq = (d < 0) ? -d : d;
    if (horiz) hdg = (d > 0) ? 8'hBF : 8'h3F;
    else       hdg = (d > 0) ? 8'h00 : 8'h7F;
    return {(horiz ? 4'h3 : 4'h2), hdg, 4'(sq)};
  endfunction

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    #1;
  endtask

  task automatic pulse_resp();
    send_resp = 1'b1;
    cyc();
    send_resp = 1'b0;
    #1;
  endtask

  // Plays the command processor for one move, with random stalls and stray strobes.
  task automatic do_move(input int i);
    int mode;
    logic [15:0] ev, eh;
    ev   = exp_cmd(tour_moves[i], 1'b0);
    eh   = exp_cmd(tour_moves[i], 1'b1);
    mode = $urandom_range(0, 3);
    chk("vert_rdy", cmd_rdy, 1);
    chk("vert_cmd", cmd, ev);
    chk("vert_idx", mv_indx, i);
    chk("vert_resp_byte", resp, 8'hA5);
    if (mode == 1) begin
      pulse_resp();
      chk("early_resp_rdy", cmd_rdy, 1);
      chk("early_resp_cmd", cmd, ev);
    end
    repeat ($urandom_range(0, 2)) cyc();
    clr_cmd_rdy = 1'b1;
    send_resp   = (mode == 2);
    #1;
    chk("uart_clr_blocked", clr_cmd_rdy_UART, 0);
    cmd_count += int'(cmd_rdy);
    cyc();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    #1;
    chk("vresp_rdy", cmd_rdy, 0);
    if (mode == 3) begin
      pulse_clr();
      chk("stray_clr_rdy", cmd_rdy, 0);
    end
    repeat ($urandom_range(0, 2)) cyc();
    chk("vresp_wait_rdy", cmd_rdy, 0);
    pulse_resp();
    chk("horz_rdy", cmd_rdy, 1);
    chk("horz_cmd", cmd, eh);
    chk("horz_idx", mv_indx, i);
    chk("horz_resp_byte", resp, 8'hA5);
    if (mode == 3) begin
      start_tour = 1'b1;
      cyc();
      start_tour = 1'b0;
      #1;
      chk("start_in_horz_idx", mv_indx, i);
      chk("start_in_horz_cmd", cmd, eh);
    end
    cmd_count += int'(cmd_rdy);
    pulse_clr();
    chk("hresp_rdy", cmd_rdy, 0);
    chk("hresp_byte", resp, (i == N - 1) ? 8'h5A : 8'hA5);
    pulse_resp();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: no finish after 500us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) tour_moves[i] = 8'h01;

    // Reset state and UART pass-through
    cmd_UART     = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #3;
    chk("rst_cmd", cmd, 16'h2003);
    chk("rst_rdy", cmd_rdy, 1);
    chk("rst_resp", resp, 8'h5A);
    chk("rst_idx", mv_indx, 0);
    #30 rst_n = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_clr_fwd", clr_cmd_rdy_UART, 1);
    chk("uart_cmd", cmd, 16'h2003);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("uart_rdy_low", cmd_rdy, 0);

    // Directed moves: 01, 08, then an invalid code
    tour_moves[0] = 8'h01;
    tour_moves[1] = 8'h08;
    tour_moves[2] = 8'h00;
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("m01_vert", cmd, 16'h2002);
    chk("m01_idx", mv_indx, 0);
    pulse_resp();
    chk("early_resp_stays", cmd_rdy, 1);
    chk("early_resp_cmd01", cmd, 16'h2002);
    pulse_clr();
    pulse_resp();
    chk("m01_horz", cmd, 16'h3BF1);
    chk("m01_horz_resp", resp, 8'hA5);
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("horz_start_ignored", mv_indx, 0);
    chk("horz_start_rdy", cmd_rdy, 1);
    pulse_clr();
    pulse_resp();
    chk("m08_vert", cmd, 16'h27F1);
    chk("m08_idx", mv_indx, 1);
    pulse_clr();
    pulse_resp();
    chk("m08_horz", cmd, 16'h33F2);
    pulse_clr();
    pulse_resp();
    chk("bad_vert", cmd, 16'h2000);
    pulse_clr();
    pulse_resp();
    chk("bad_horz", cmd, 16'h3000);
    chk("bad_horz_rdy", cmd_rdy, 1);
    pulse_resp();
    pulse_clr();
    pulse_resp();
    pulse_clr();
    chk("vresp_before_rst", cmd_rdy, 0);
    chk("vresp_before_rst_idx", mv_indx, 3);

    // Asynchronous reset in VERT_RESP
    cmd_UART     = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    rst_n        = 1'b0;
    #1;
    chk("arst_idx", mv_indx, 0);
    chk("arst_cmd", cmd, 16'hBEEF);
    chk("arst_rdy", cmd_rdy, 1);
    chk("arst_resp", resp, 8'h5A);
    #5 rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    cyc();
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    chk("restart_idx", mv_indx, 0);
    chk("restart_cmd", cmd, 16'h2002);
    rst_n = 1'b0;
    #5 rst_n = 1'b1;
    cyc();

    // Random full tours
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++)
        tour_moves[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      cmd_rdy_UART = 1'b0;
      start_tour = 1'b1;
      cyc();
      start_tour = 1'b0;
      #1;
      cmd_count = 0;
      for (int i = 0; i < N; i++) do_move(i);
      chk("tour_cmd_count", cmd_count, 2 * N);
      cmd_UART     = 16'($urandom);
      cmd_rdy_UART = 1'($urandom);
      #1;
      chk("post_tour_cmd", cmd, cmd_UART);
      chk("post_tour_rdy", cmd_rdy, cmd_rdy_UART);
      chk("post_tour_resp", resp, 8'h5A);
      repeat (2) cyc();
      chk("post_tour_idle_cmd", cmd, cmd_UART);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter NUM_MOVES, default 24, number of knight moves in a full tour (5x5 board).
REQ-002 clk  input  1  50MHz system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_tour  input  1  one-cycle pulse that launches a tour.
REQ-005 move  input  8  one-hot knight move for the current index, from the tour solver.
REQ-006 mv_indx  output  5  index of the move being executed; selects move in the solver.
REQ-007 cmd_UART  input  16  command from the BLE/UART wrapper.
REQ-008 cmd_rdy_UART  input  1  UART command valid.
REQ-009 clr_cmd_rdy_UART  output  1  forwarded consume strobe to the UART wrapper.
REQ-010 cmd  output  16  command to the command processor: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-011 cmd_rdy  output  1  command valid to the command processor.
REQ-012 clr_cmd_rdy  input  1  command processor consumed cmd.
REQ-013 send_resp  input  1  command processor finished the command.
REQ-014 resp  output  8  response byte for the UART wrapper.

Function
REQ-015 States SHALL be IDLE, VERT, VERT_RESP, HORZ and HORZ_RESP.
REQ-016 In IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and clr_cmd_rdy_UART=clr_cmd_rdy (UART pass-through).
REQ-017 Outside IDLE: clr_cmd_rdy_UART=0; cmd and cmd_rdy are driven by this block only.
REQ-018 IDLE + start_tour: mv_indx<=0 and next state is VERT; start_tour outside IDLE is ignored.
REQ-019 VERT: cmd_rdy=1 with the vertical command, opcode 4'h2; clr_cmd_rdy moves to VERT_RESP.
REQ-020 VERT_RESP: cmd_rdy=0; send_resp moves to HORZ.
REQ-021 HORZ: cmd_rdy=1 with the horizontal command, opcode 4'h3 (move plus fanfare); clr_cmd_rdy moves to HORZ_RESP.
REQ-022 HORZ_RESP: cmd_rdy=0.
- On send_resp with mv_indx==NUM_MOVES-1: next state is IDLE.
- On any other send_resp: mv_indx increments and next state is VERT.
REQ-023 Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF. +y is north; +x is east.
REQ-024 move decode (dx,dy):
- b0 (+1,+2)
- b1 (-1,+2)
- b2 (-2,+1)
- b3 (-2,-1)
- b4 (-1,-2)
- b5 (+1,-2)
- b6 (+2,-1)
- b7 (+2,+1)
REQ-025 Decode output: vertical squares=|dy| and heading from sign(dy); horizontal squares=|dx| and heading from sign(dx); cmd[3:0] is zero-extended.
REQ-026 move is zero or not one-hot: both commands are emitted with squares 0 and heading north; the state machine sequences normally.
REQ-027 move is sampled combinationally in VERT and HORZ; mv_indx is stable from VERT through HORZ_RESP of the same move.
REQ-028 clr_cmd_rdy or send_resp arriving in a state that does not wait for it is ignored.
REQ-029 clr_cmd_rdy and send_resp asserted together in VERT: only the VERT->VERT_RESP transition occurs; the next send_resp is still required.
REQ-030 resp = 8'h5A in IDLE, and in HORZ_RESP when mv_indx==NUM_MOVES-1; otherwise 8'hA5.
REQ-031 All state transitions take effect one clk after the qualifying input; outputs are combinational from state, mv_indx and move.

Reset
REQ-032 rst_n low: state=IDLE, mv_indx=0, cmd_rdy=cmd_rdy_UART (pass-through), resp=8'h5A, all asynchronous.
REQ-033 Reset asserted mid-tour aborts the tour; the next start_tour restarts at mv_indx=0.

Structure
REQ-034 Package tour_pkg SHALL hold:
- the state enum;
- opcode constants MOVE=4'h2 and MOVE_FANFARE=4'h3;
- heading constants;
- response constants ACK_MID=8'hA5 and ACK_DONE=8'h5A;
- NUM_MOVES default.
REQ-035 Sub-module knight_move_decode (combinational) maps move[7:0] to {vert_hdg, vert_sq, horz_hdg, horz_sq}.
REQ-036 The state register, mv_indx counter and output mux reside in tour_cmd.

Verification
REQ-037 UART pass-through: IDLE, cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1.
REQ-038 Single move: start_tour, move=8'h01 -> cmd=16'h2002 in VERT; clr_cmd_rdy then send_resp; -> cmd=16'h3BF1 in HORZ with resp=8'hA5.
REQ-039 Move 8'h08 -> vertical 16'h27F1, horizontal 16'h33F2.
REQ-040 Full tour: 24 moves with a responding model -> exactly 48 commands, mv_indx 0..23, resp=8'h5A at the final send_resp, then IDLE.
REQ-041 start_tour while in HORZ -> ignored (mv_indx unchanged); rst_n low in VERT_RESP -> IDLE, mv_indx=0, cmd follows cmd_UART.
REQ-042 Premature send_resp in VERT -> state stays VERT, cmd_rdy remains 1.
